// File: rtl/mmap_pkg.sv
// Shared types and register-map constants for the mmap register port
// arbiter and its users.
package mmap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mmap_arb_state_t;

  localparam logic [3:0] MMAP_BR_CNT    = 4'h0;
  localparam logic [3:0] MMAP_MISPR_CNT = 4'h1;
  localparam logic [3:0] MMAP_HIT_CNT   = 4'h2;
  localparam logic [3:0] MMAP_TIMER     = 4'h3;
  localparam logic [3:0] MMAP_KEY_UP    = 4'h4;
  localparam logic [3:0] MMAP_KEY_DOWN  = 4'h5;
  localparam logic [3:0] MMAP_STATS_WR  = 4'hB;

endpackage

// File: rtl/mmap_arb_rr_arb2.sv
// Combinational two-way round-robin picker; a lock held by m1 hides m0's
// request entirely so the preference pointer does not matter while locked.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock_owner,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  // mask by lock ownership, then pick; pointer only breaks ties
  always_comb begin
    elig = req;
    gnt  = 2'b00;
    if (lock_owner) begin
      elig = {req[1], 1'b0};
    end else begin
      elig = req;
    end
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mmap_arb.sv
// Arbiter and three-cycle bus sequencer sharing the mmap register port
// between the CPU path (m0) and the debug/stats-dump engine (m1).
module mmap_arb
  import mmap_pkg::*;
#(
  parameter int                ADDR_W        = 4,
  parameter int                DATA_W        = 16,
  parameter int                NUM_RD_REGS   = 6,
  parameter logic [ADDR_W-1:0] STATS_WR_ADDR = MMAP_STATS_WR,
  parameter int                LOCK_MAX      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mmap_re,
  output logic [ADDR_W-1:0] mmap_addr,
  output logic              br_stats_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_oe,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int                CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  LOCK_LIM = CNT_W'(LOCK_MAX - 1);
  localparam logic [ADDR_W:0]   NUM_RD   = NUM_RD_REGS[ADDR_W:0];

  mmap_arb_state_t   state, state_nxt;
  logic [1:0]        pick, gnt;
  logic              ptr, lock_owner;
  logic [CNT_W-1:0]  lock_cnt;
  logic              cap_we, cap_m1;
  logic [ADDR_W-1:0] cap_addr;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_pick (
    .req        ({m1_req, m0_req}),
    .ptr        (ptr),
    .lock_owner (lock_owner),
    .gnt        (pick)
  );

  assign gnt    = (state == IDLE && !rst) ? pick : 2'b00;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // winner's request fields
  always_comb begin
    win_we    = 1'b0;
    win_addr  = {ADDR_W{1'b0}};
    win_wdata = {DATA_W{1'b0}};
    if (gnt[1]) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end else begin
      win_we    = m0_we;
      win_addr  = m0_addr;
      win_wdata = m0_wdata;
    end
  end

  // out-of-range reads and writes return zero: the bus may be floating
  always_comb begin
    resp_data = {DATA_W{1'b0}};
    if (!cap_we && ({1'b0, cap_addr} < NUM_RD)) begin
      resp_data = bus_rdata;
    end else begin
      resp_data = {DATA_W{1'b0}};
    end
  end

  // transaction sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|gnt) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pointer and lock bookkeeping; a locked grant keeps the pointer as is
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= {CNT_W{1'b0}};
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      if (m1_lock && (lock_cnt < LOCK_LIM)) begin
        lock_owner <= 1'b1;
        lock_cnt   <= lock_cnt + CNT_W'(1);
      end else begin
        lock_owner <= 1'b0;
        lock_cnt   <= {CNT_W{1'b0}};
        ptr        <= 1'b0;
      end
    end
  end

  // capture registers and registered bus/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we      <= 1'b0;
      cap_m1      <= 1'b0;
      cap_addr    <= {ADDR_W{1'b0}};
      mmap_re     <= 1'b0;
      mmap_addr   <= {ADDR_W{1'b0}};
      br_stats_wr <= 1'b0;
      wr_oe       <= 1'b0;
      wr_data     <= {DATA_W{1'b0}};
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= {DATA_W{1'b0}};
      m1_rdata    <= {DATA_W{1'b0}};
    end else begin
      mmap_re     <= 1'b0;
      mmap_addr   <= {ADDR_W{1'b0}};
      br_stats_wr <= 1'b0;
      wr_oe       <= 1'b0;
      wr_data     <= {DATA_W{1'b0}};
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= {DATA_W{1'b0}};
      m1_rdata    <= {DATA_W{1'b0}};
      case (state)
        IDLE: begin
          if (|gnt) begin
            cap_we    <= win_we;
            cap_m1    <= gnt[1];
            cap_addr  <= win_addr;
            mmap_addr <= win_addr;
            mmap_re   <= !win_we;
            if (win_we && (win_addr == STATS_WR_ADDR)) begin
              br_stats_wr <= 1'b1;
              wr_oe       <= 1'b1;
              wr_data     <= win_wdata;
            end
          end
        end
        ACCESS: begin
          if (cap_m1) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= resp_data;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= resp_data;
          end
        end
        RESP: begin
          cap_we <= cap_we;
        end
        default: begin
          cap_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
